// File: rtl/kabeta_irq_pkg.sv
// Shared types and constants for the Kabeta core interrupt controller.
package kabeta_irq_pkg;

  localparam int unsigned DEF_NUM_SRC     = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    WAIT_S = 2'b10
  } irq_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/kabeta_irq_controller_irq_sync.sv
// Single-bit multi-flop synchroniser with asynchronous active-high reset.
module irq_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/kabeta_irq_controller.sv
// Multi-source fixed-priority interrupt controller feeding the branch-exception unit.
// Define IRQ_EDGE_DETECT_EN for edge-latched pending; default build is level mode.
module kabeta_irq_controller
  import kabeta_irq_pkg::*;
#(
  parameter int unsigned         NUM_SRC     = DEF_NUM_SRC,
  parameter int unsigned         ID_W        = clog2(NUM_SRC),
  parameter int unsigned         SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic [NUM_SRC-1:0]  MASK_INIT   = '1
) (
  input  logic               Sys_Clock,
  input  logic               Sys_Reset,
  input  logic [NUM_SRC-1:0] Irq_Src,
  input  logic               Irq_Mask_Wr,
  input  logic [NUM_SRC-1:0] Irq_Mask_Data,
  input  logic               S_Mode_IF,
  input  logic               KIU_I_Ack,
  output logic               KIU_I_Req,
  output logic [ID_W-1:0]    KIU_I_Id,
  output logic [NUM_SRC-1:0] Irq_Src_Ack,
  output logic [NUM_SRC-1:0] Irq_Pending,
  output logic [NUM_SRC-1:0] Irq_Mask
);

  logic [NUM_SRC-1:0] w_sync;
  logic [NUM_SRC-1:0] w_elig;
  logic               w_any;
  logic [ID_W-1:0]    w_win_id;

  irq_state_e         r_state, w_state_nxt;
  logic               r_req, w_req_nxt;
  logic [ID_W-1:0]    r_id, w_id_nxt;
  logic [NUM_SRC-1:0] r_ack, w_ack_nxt;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_mask;
`ifdef IRQ_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] r_sync_d;
`endif

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .i_clk (Sys_Clock),
      .i_rst (Sys_Reset),
      .i_d   (Irq_Src[g]),
      .o_q   (w_sync[g])
    );
  end

  assign w_elig = r_pending & r_mask;
  assign w_any  = |w_elig;

  // Fixed priority: scanning downward leaves the lowest eligible index.
  always_comb begin
    w_win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win_id = ID_W'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = 1'b0;
    w_id_nxt    = '0;
    w_ack_nxt   = '0;
    case (r_state)
      IDLE: begin
        if (w_any && !S_Mode_IF) begin
          w_state_nxt = REQ;
          w_req_nxt   = 1'b1;
          w_id_nxt    = w_win_id;
        end
      end
      REQ: begin
        if (KIU_I_Ack) begin
          w_state_nxt = WAIT_S;
          w_ack_nxt   = NUM_SRC'(1) << r_id;
        end else if (S_Mode_IF) begin
          w_state_nxt = IDLE;
        end else begin
          w_req_nxt = 1'b1;
          w_id_nxt  = r_id;
        end
      end
      // Hold off until the core's mode switch is visible on the IF stage.
      WAIT_S: begin
        if (S_Mode_IF) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_id    <= '0;
      r_ack   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_id    <= w_id_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      r_mask <= MASK_INIT;
    end else if (Irq_Mask_Wr) begin
      r_mask <= Irq_Mask_Data;
    end
  end

  // Edge mode: a fresh rising edge overrides the grant clear of the same bit.
`ifdef IRQ_EDGE_DETECT_EN
  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      r_sync_d  <= '0;
      r_pending <= '0;
    end else begin
      r_sync_d  <= w_sync;
      r_pending <= (r_pending & ~w_ack_nxt) | (w_sync & ~r_sync_d);
    end
  end
`else
  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) r_pending <= '0;
    else           r_pending <= w_sync;
  end
`endif

  assign KIU_I_Req   = r_req;
  assign KIU_I_Id    = r_id;
  assign Irq_Src_Ack = r_ack;
  assign Irq_Pending = r_pending;
  assign Irq_Mask    = r_mask;

endmodule

// File: tb/tb_kabeta_irq_controller.sv
// Directed bench for kabeta_irq_controller (NUM_SRC=4, SYNC_STAGES=2).
module tb_kabeta_irq_controller;

  logic       clk;
  logic       rst;
  logic [3:0] src;
  logic       mask_wr;
  logic [3:0] mask_data;
  logic       s_mode;
  logic       ack_in;
  logic       req;
  logic [1:0] id;
  logic [3:0] src_ack;
  logic [3:0] pend;
  logic [3:0] mask;

  int checks = 0;
  int errors = 0;

  kabeta_irq_controller dut (
    .Sys_Clock     (clk),
    .Sys_Reset     (rst),
    .Irq_Src       (src),
    .Irq_Mask_Wr   (mask_wr),
    .Irq_Mask_Data (mask_data),
    .S_Mode_IF     (s_mode),
    .KIU_I_Ack     (ack_in),
    .KIU_I_Req     (req),
    .KIU_I_Id      (id),
    .Irq_Src_Ack   (src_ack),
    .Irq_Pending   (pend),
    .Irq_Mask      (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; src = '0; mask_wr = 1'b0; mask_data = '0; s_mode = 1'b0; ack_in = 1'b0;
    step(2);
    chk("rst_req",  32'(req), 32'd0);
    chk("rst_id",   32'(id), 32'd0);
    chk("rst_ack",  32'(src_ack), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    chk("rst_mask", 32'(mask), 32'hF);

    // Single source 2: request four edges after the source rises.
    rst = 1'b0; src = 4'b0100;
    step(3);
    chk("t1_req_e3",  32'(req), 32'd0);
    chk("t1_pend_e3", 32'(pend), 32'h4);
    step(1);
    chk("t1_req_e4", 32'(req), 32'd1);
    chk("t1_id_e4",  32'(id), 32'd2);
    step(1);
    chk("t1_req_e5", 32'(req), 32'd1);
    ack_in = 1'b1;
    step(1);
    chk("t1_req_e6", 32'(req), 32'd0);
    chk("t1_id_e6",  32'(id), 32'd0);
    chk("t1_ack_e6", 32'(src_ack), 32'h4);
`ifdef IRQ_EDGE_DETECT_EN
    chk("t1_pend_e6", 32'(pend), 32'h0);
`else
    chk("t1_pend_e6", 32'(pend), 32'h4);
`endif
    ack_in = 1'b0; src = '0;
    step(1);
    chk("t1_ack_e7", 32'(src_ack), 32'h0);
    step(2);
    chk("t1_pend_e9", 32'(pend), 32'h0);
    s_mode = 1'b1;
    step(1);
    s_mode = 1'b0;
    step(1);

    // Two simultaneous sources: 1 wins, then 3 after the mode handshake.
    src = 4'b1010;
    step(4);
    chk("t2_req_a",  32'(req), 32'd1);
    chk("t2_id_a",   32'(id), 32'd1);
    ack_in = 1'b1;
    step(1);
    chk("t2_ack_a",  32'(src_ack), 32'h2);
    chk("t2_req_a5", 32'(req), 32'd0);
    ack_in = 1'b0; src = 4'b1000; s_mode = 1'b1;
    step(3);
    chk("t2_req_smode", 32'(req), 32'd0);
    chk("t2_pend_a8",   32'(pend), 32'h8);
    s_mode = 1'b0;
    step(1);
    chk("t2_req_b", 32'(req), 32'd1);
    chk("t2_id_b",  32'(id), 32'd3);
    ack_in = 1'b1;
    step(1);
    chk("t2_ack_b", 32'(src_ack), 32'h8);
    ack_in = 1'b0; src = '0; s_mode = 1'b1;
    step(4);
    chk("t2_pend_end", 32'(pend), 32'h0);
    chk("t2_req_end",  32'(req), 32'd0);
    s_mode = 1'b0;
    step(1);

    // Masked source stays pending; unmask uses old mask on the write edge.
    mask_wr = 1'b1; mask_data = 4'b1101; src = 4'b0010;
    step(1);
    chk("t3_mask_wr", 32'(mask), 32'hD);
    mask_wr = 1'b0;
    step(4);
    chk("t3_req_masked",  32'(req), 32'd0);
    chk("t3_pend_masked", 32'(pend), 32'h2);
    mask_wr = 1'b1; mask_data = 4'b1111;
    step(1);
    chk("t3_mask_open",   32'(mask), 32'hF);
    chk("t3_req_oldmask", 32'(req), 32'd0);
    mask_wr = 1'b0;
    step(1);
    chk("t3_req_unmask", 32'(req), 32'd1);
    chk("t3_id_unmask",  32'(id), 32'd1);
    s_mode = 1'b1;
    step(1);
    chk("t3_req_withdrawn", 32'(req), 32'd0);
    chk("t3_id_withdrawn",  32'(id), 32'd0);
    chk("t3_pend_kept",     32'(pend), 32'h2);
    step(1);
    chk("t3_req_blocked", 32'(req), 32'd0);
    s_mode = 1'b0;
    step(1);
    chk("t3_req_reissue", 32'(req), 32'd1);
    chk("t3_id_reissue",  32'(id), 32'd1);
    ack_in = 1'b1; s_mode = 1'b1;
    step(1);
    chk("t3_ack_wins", 32'(src_ack), 32'h2);
    chk("t3_req_ackd", 32'(req), 32'd0);
    ack_in = 1'b0; src = '0;
    step(4);
    chk("t3_pend_end", 32'(pend), 32'h0);
    s_mode = 1'b0;
    step(1);

    // Asynchronous reset in the middle of a handshake.
    mask_wr = 1'b1; mask_data = 4'b0101; src = 4'b0100;
    step(1);
    mask_wr = 1'b0;
    step(3);
    chk("t4_req_pre",  32'(req), 32'd1);
    chk("t4_id_pre",   32'(id), 32'd2);
    chk("t4_mask_pre", 32'(mask), 32'h5);
    #2;
    ack_in = 1'b1; rst = 1'b1;
    #1;
    chk("t4_req_async",  32'(req), 32'd0);
    chk("t4_id_async",   32'(id), 32'd0);
    chk("t4_ack_async",  32'(src_ack), 32'h0);
    chk("t4_pend_async", 32'(pend), 32'h0);
    chk("t4_mask_async", 32'(mask), 32'hF);
    step(2);
    chk("t4_ack_held", 32'(src_ack), 32'h0);
    chk("t4_req_held", 32'(req), 32'd0);
    src = '0; ack_in = 1'b0; rst = 1'b0;
    step(2);

    // Source 0 re-requests: held level, or a new edge landing on the clear edge.
    src = 4'b0001;
    step(2);
`ifdef IRQ_EDGE_DETECT_EN
    src = 4'b0000;
`endif
    step(1);
`ifdef IRQ_EDGE_DETECT_EN
    src = 4'b0001;
`endif
    step(1);
    chk("t5_req_a", 32'(req), 32'd1);
    chk("t5_id_a",  32'(id), 32'd0);
    step(1);
    ack_in = 1'b1;
    step(1);
    chk("t5_ack",       32'(src_ack), 32'h1);
    chk("t5_pend_ackd", 32'(pend), 32'h1);
    ack_in = 1'b0; s_mode = 1'b1;
    step(1);
    chk("t5_req_wait", 32'(req), 32'd0);
    s_mode = 1'b0;
    step(1);
    chk("t5_req_again", 32'(req), 32'd1);
    chk("t5_id_again",  32'(id), 32'd0);
    chk("t5_pend_again", 32'(pend), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kabeta_irq_controller.md
# kabeta_irq_controller

Parametrised core interrupt controller for the Kabeta pipeline: the multi-source successor to the single-request core interrupt unit. It synchronises NUM_SRC asynchronous peripheral requests, holds them in pending latches with per-source masking, and selects the highest-priority eligible source by fixed priority. It presents one request/ID pair to the branch-exception unit and returns a per-source acknowledge pulse. It sits between the external peripherals and the core's exception logic.

## Interface
- NUM_SRC, 4: number of interrupt sources (2..32).
- ID_W, clog2(NUM_SRC): width of the source ID (derived; do not override).
- SYNC_STAGES, 2: synchroniser depth per source (>=2).
- MASK_INIT, all ones: reset value of the enable mask (1 = enabled).

Ports:
- Sys_Clock  in  1  single system clock.
- Sys_Reset  in  1  reset, asynchronous, active-high.
- Irq_Src  in  NUM_SRC  asynchronous peripheral requests.
- Irq_Mask_Wr  in  1  loads Irq_Mask_Data into the mask register.
- Irq_Mask_Data  in  NUM_SRC  new mask value.
- S_Mode_IF  in  1  supervisor bit of the IF-stage PC; 1 blocks new requests.
- KIU_I_Ack  in  1  core accepts the current request.
- KIU_I_Req  out  1  interrupt request to the exception unit.
- KIU_I_Id  out  ID_W  ID of the requested source.
- Irq_Src_Ack  out  NUM_SRC  one-hot, one-cycle acknowledge to the granted source.
- Irq_Pending  out  NUM_SRC  pending register, readable via IO.
- Irq_Mask  out  NUM_SRC  current mask register.

## Operation
- Each Irq_Src bit passes through a SYNC_STAGES-flop synchroniser, then feeds pending[i]. The update rule is set under Configuration.
- Eligible = pending & mask. The lowest index has the highest priority.
- FSM states and transitions:
  - IDLE → REQ when eligible ≠ 0 and S_Mode_IF = 0. The winning ID is captured into KIU_I_Id and frozen.
  - REQ, KIU_I_Ack = 1: on that edge KIU_I_Req drops, Irq_Src_Ack[id] is set for exactly one cycle, pending[id] is cleared (edge mode), and the FSM goes to WAIT_S.
  - REQ, KIU_I_Ack = 0 and S_Mode_IF = 1: withdraw the request and go to IDLE. Pending is kept.
  - REQ, KIU_I_Ack = 1 and S_Mode_IF = 1 in the same cycle: the ack wins.
  - WAIT_S → IDLE when S_Mode_IF = 1 (the core has entered its handler). This prevents a second request being issued before the mode switch becomes visible.
- A mask write or a higher-priority arrival during REQ does not change the frozen ID.
- Mask write takes effect on the next edge. A mask change in the same cycle as the IDLE→REQ decision uses the old mask.

## Timing
- Reset values: KIU_I_Req = 0, KIU_I_Id = 0, Irq_Src_Ack = 0, Irq_Pending = 0, Irq_Mask = MASK_INIT, synchronisers = 0, state = IDLE.
- All outputs are registered.
- Latency: a source high at clock edge k raises KIU_I_Req at edge k+SYNC_STAGES+2 (SYNC_STAGES synchroniser edges, 1 pending edge, 1 FSM edge), provided it is unmasked, highest priority and S_Mode_IF = 0.
- KIU_I_Id is valid and stable while KIU_I_Req = 1, and is 0 otherwise.
- Irq_Src_Ack is asserted on the cycle after the ack edge.
- Minimum spacing between two requests: ack → WAIT_S → (S_Mode_IF seen 1) → IDLE → (S_Mode_IF back to 0) → REQ.
- Reset mid-handshake: all outputs return to their reset values immediately (asynchronous); no ack pulse is issued.

## Configuration
- IRQ_EDGE_DETECT_EN defined:
  - A synchronised rising edge sets pending[i]; pending is cleared only by the grant ack.
  - A set and a clear of the same bit in the same cycle: set wins.
  - Pending captures edges even while the source is masked.
- IRQ_EDGE_DETECT_EN undefined (level mode):
  - pending[i] <= synchronised level each cycle; there is no clear on ack.
  - The source must hold its request until it sees Irq_Src_Ack and must then drop it.
  - A source still high after WAIT_S re-requests.

## Structure
- Shared package kabeta_irq_pkg holds:
  - state encodings: IDLE = 2'b00, REQ = 2'b01, WAIT_S = 2'b10;
  - a clog2 function;
  - default parameter constants.
- Sub-module irq_sync: a SYNC_STAGES-deep single-bit synchroniser with asynchronous reset, instantiated NUM_SRC times.
- The priority encoder, pending logic and FSM stay in the top level.

## Test plan
- Reset, mask = 4'b1111, Irq_Src = 4'b0100 at edge 0 → KIU_I_Req = 1, KIU_I_Id = 2 at edge 4; ack at edge 6 → Irq_Src_Ack = 4'b0100 for one cycle; Irq_Pending[2] = 0 in edge mode.
- Irq_Src = 4'b1010 simultaneously → KIU_I_Id = 1. After ack, S_Mode_IF pulses 1 then 0 → a second request follows with KIU_I_Id = 3.
- Mask write 4'b1101, Irq_Src[1] edge → no request and Irq_Pending = 4'b0010. Mask write 4'b1111 with S_Mode_IF = 0 → request with ID 1 on the next FSM edge.
- S_Mode_IF = 1 while a source is pending → KIU_I_Req stays 0. S_Mode_IF rising during REQ without ack → request withdrawn, pending retained, re-issued when S_Mode_IF = 0.
- Sys_Reset asserted while KIU_I_Req = 1 → all outputs 0 asynchronously; Irq_Mask = MASK_INIT.
- Level mode (macro undefined): source held high through ack and through WAIT_S → request re-issued after S_Mode_IF returns to 0. Edge mode: a new edge arriving in the clear cycle → pending stays 1.
